// File: rtl/fpu_seq.sv
// Handshaked IEEE-754-style floating-point unit: add/sub/mul at fixed latency, iterative restoring div.
// Optional divider datapath is built only when the macro FPU_DIV_EN is defined.
module fpu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [1:0]             opcode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int AW = MAN_W + 4;
    localparam int NW = MAN_W + 5;
    localparam int XW = EXP_W + 2;
    localparam int LW = $clog2(NW);
    localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_DIV = 2'b10, OP_MUL = 2'b11;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, EXEC, NORM, DONE} state_t;
    state_t state, state_n;

    logic [W-1:0] a_r, b_r;
    logic [1:0]   op_r;

    // Unpack the latched operands; denormals flush to zero with their sign kept.
    logic sa, sb, sbe, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0] ea, eb;
    logic [SW-1:0]    ma, mb;
    assign sa     = a_r[W-1];
    assign sb     = b_r[W-1];
    assign ea     = a_r[W-2:MAN_W];
    assign eb     = b_r[W-2:MAN_W];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (a_r[MAN_W-1:0] == '0);
    assign b_inf  = (eb == '1) && (b_r[MAN_W-1:0] == '0);
    assign a_nan  = (ea == '1) && (a_r[MAN_W-1:0] != '0);
    assign b_nan  = (eb == '1) && (b_r[MAN_W-1:0] != '0);
    assign ma     = a_zero ? '0 : {1'b1, a_r[MAN_W-1:0]};
    assign mb     = b_zero ? '0 : {1'b1, b_r[MAN_W-1:0]};
    assign sbe    = (op_r == OP_SUB) ? ~sb : sb;

    logic             a_big, s_big;
    logic [EXP_W-1:0] e_big, e_small, diff;
    logic [AW-1:0]    m_big, m_small, m_align, lost_mask;
    logic [NW-1:0]    sum;
    logic [2*SW-1:0]  prod;

    always_comb begin
        a_big     = (a_r[W-2:0] >= b_r[W-2:0]);
        s_big     = a_big ? sa : sbe;
        e_big     = a_big ? ea : eb;
        e_small   = a_big ? eb : ea;
        m_big     = a_big ? {ma, 3'b000} : {mb, 3'b000};
        m_small   = a_big ? {mb, 3'b000} : {ma, 3'b000};
        diff      = e_big - e_small;
        lost_mask = ~({AW{1'b1}} << diff);
        if (32'(diff) > MAN_W + 3)
            m_align = '0;
        else
            m_align = (m_small >> diff) | {{(AW-1){1'b0}}, |(m_small & lost_mask)};
        if (sa ^ sbe)
            sum = {1'b0, m_big} - {1'b0, m_align};
        else
            sum = {1'b0, m_big} + {1'b0, m_align};
        prod = ma * mb;
    end

`ifdef FPU_DIV_EN
    localparam int CW = $clog2(MAN_W + 2);
    logic [CW-1:0] cnt;
    logic [SW:0]   rem_r, rem_cur, rem_sub, rem_n, q_r, q_cur, q_n;
    logic          q_bit, div_last;

    // One restoring step per EXEC cycle; the first step seeds from the dividend significand.
    always_comb begin
        rem_cur  = (cnt == '0) ? {1'b0, ma} : rem_r;
        q_cur    = (cnt == '0) ? '0 : q_r;
        q_bit    = (rem_cur >= {1'b0, mb});
        rem_sub  = q_bit ? (rem_cur - {1'b0, mb}) : rem_cur;
        rem_n    = rem_sub << 1;
        q_n      = (q_cur << 1) | {{SW{1'b0}}, q_bit};
        div_last = (cnt == CW'(MAN_W + 1));
    end

    always_ff @(posedge clk) begin
        if (state == IDLE)
            cnt <= '0;
        else if (state == EXEC) begin
            cnt   <= cnt + 1'b1;
            rem_r <= rem_n;
            q_r   <= q_n;
        end
    end
`endif

    logic             x_sign, x_spec;
    logic [XW-1:0]    x_exp;
    logic [NW-1:0]    x_buf;
    logic [W-1:0]     x_spec_res;
    logic [3:0]       x_spec_flags;

    // Datapath result in a common buffer: leading one nominally at bit MAN_W+3, carry above it.
    always_comb begin
        x_sign       = sa ^ sb;
        x_exp        = '0;
        x_buf        = '0;
        x_spec       = 1'b0;
        x_spec_res   = '0;
        x_spec_flags = '0;
        case (op_r)
            OP_ADD, OP_SUB: begin
                x_sign = (sum == '0) ? (sa & sbe) : s_big;
                x_exp  = XW'(e_big);
                x_buf  = sum;
            end
            OP_MUL: begin
                x_exp = XW'(ea) + XW'(eb) - BIAS;
                x_buf = NW'(prod >> (MAN_W - 3));
            end
            default: begin
`ifdef FPU_DIV_EN
                x_exp = XW'(ea) - XW'(eb) + BIAS;
                x_buf = {1'b0, q_n, 2'b00};
`endif
            end
        endcase

        if (a_nan || b_nan) begin
            x_spec = 1'b1; x_spec_res = QNAN; x_spec_flags = 4'b1000;
        end else begin
            case (op_r)
                OP_ADD, OP_SUB: begin
                    if (a_inf && b_inf && (sa != sbe)) begin
                        x_spec = 1'b1; x_spec_res = QNAN; x_spec_flags = 4'b1000;
                    end else if (a_inf) begin
                        x_spec = 1'b1; x_spec_res = {sa, INF_MAG};
                    end else if (b_inf) begin
                        x_spec = 1'b1; x_spec_res = {sbe, INF_MAG};
                    end
                end
                OP_MUL: begin
                    if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                        x_spec = 1'b1; x_spec_res = QNAN; x_spec_flags = 4'b1000;
                    end else if (a_inf || b_inf) begin
                        x_spec = 1'b1; x_spec_res = {sa ^ sb, INF_MAG};
                    end
                end
                default: begin
`ifdef FPU_DIV_EN
                    if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        x_spec = 1'b1; x_spec_res = QNAN; x_spec_flags = 4'b1000;
                    end else if (a_inf) begin
                        x_spec = 1'b1; x_spec_res = {sa ^ sb, INF_MAG};
                    end else if (b_zero) begin
                        x_spec = 1'b1; x_spec_res = {sa ^ sb, INF_MAG}; x_spec_flags = 4'b0100;
                    end else if (b_inf) begin
                        x_spec = 1'b1; x_spec_res = {sa ^ sb, {(W-1){1'b0}}};
                    end
`else
                    x_spec = 1'b1; x_spec_res = QNAN; x_spec_flags = 4'b1000;
`endif
                end
            endcase
        end
    end

    logic             n_sign, n_spec;
    logic [XW-1:0]    n_exp, e_norm;
    logic [NW-1:0]    n_buf;
    logic [W-1:0]     n_spec_res, norm_res;
    logic [3:0]       n_spec_flags, norm_flags;
    logic [LW-1:0]    lead, sh;
    logic [MAN_W-1:0] frac;

    // Leading-one normalise, truncate, then range-check; special values win.
    always_comb begin
        lead = '0;
        for (int i = 0; i < NW; i++)
            if (n_buf[i]) lead = LW'(i);
        sh = LW'(MAN_W + 3) - lead;
        if (n_buf[NW-1]) begin
            frac   = n_buf[MAN_W+3:4];
            e_norm = n_exp + XW'(1);
        end else begin
            frac   = MAN_W'((n_buf << sh) >> 3);
            e_norm = n_exp - XW'(sh);
        end
        norm_flags = 4'b0000;
        if (n_spec) begin
            norm_res   = n_spec_res;
            norm_flags = n_spec_flags;
        end else if (n_buf == '0) begin
            norm_res = {n_sign, {(W-1){1'b0}}};
        end else if (!e_norm[XW-1] && (e_norm >= EMAX)) begin
            norm_res   = {n_sign, INF_MAG};
            norm_flags = 4'b0010;
        end else if (e_norm[XW-1] || (e_norm == '0)) begin
            norm_res   = {n_sign, {(W-1){1'b0}}};
            norm_flags = 4'b0001;
        end else begin
            norm_res = {n_sign, e_norm[EXP_W-1:0], frac};
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = EXEC;
`ifdef FPU_DIV_EN
            EXEC: if ((op_r != OP_DIV) || div_last) state_n = NORM;
`else
            EXEC: state_n = NORM;
`endif
            NORM: state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_n;
            if (state == NORM) begin
                result <= norm_res;
                flags  <= norm_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= opcode;
        end
        if (state == EXEC) begin
            n_sign       <= x_sign;
            n_exp        <= x_exp;
            n_buf        <= x_buf;
            n_spec       <= x_spec;
            n_spec_res   <= x_spec_res;
            n_spec_flags <= x_spec_flags;
        end
    end
endmodule

// File: tb/tb_fpu_seq.sv
// Directed, table-driven bench for fpu_seq with hand-computed results, latency and handshake checks.
// Expectations for opcode 10 follow whether FPU_DIV_EN is defined for the build.
module tb_fpu_seq;
    localparam int MAN_W = 23;
`ifdef FPU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [1:0]  opcode;
    logic [3:0]  flags;

    int checks = 0;
    int fails  = 0;

    fpu_seq #(.EXP_W(8), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;
    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one operation, wait for acceptance, then count negedges until out_valid (bounded).
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                                 output int lat, output logic ir1);
        @(negedge clk);
        a = ta; b = tb; opcode = top; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678; opcode = ~top;
        lat = 1;
        ir1 = in_ready;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) $display("[TB] FAIL timeout waiting for out_valid after %0d cycles", lat);
    endtask

    task automatic runVector(input vec_t v);
        int   lat;
        int   explat;
        logic ir1;
        out_ready = 1'b1;
        explat = (DIV_ON && v.op == 2'b10) ? MAN_W + 4 : 3;
        applyStimulus(v.a, v.b, v.op, lat, ir1);
        checkOutput({v.name, " in_ready@1"}, {31'b0, ir1}, 32'd0);
        checkOutput({v.name, " latency"}, lat, explat);
        checkOutput({v.name, " result"}, result, v.res);
        checkOutput({v.name, " flags"}, {28'b0, flags}, {28'b0, v.flg});
        @(negedge clk);
        checkOutput({v.name, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
        checkOutput({v.name, " in_ready back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        logic ir1;

        vecs.push_back('{"add 1.5+2.25",  32'h3FC00000, 32'h40100000, 2'b00, 32'h40700000, 4'b0000});
        vecs.push_back('{"sub 3-5",       32'h40400000, 32'h40A00000, 2'b01, 32'hC0000000, 4'b0000});
        vecs.push_back('{"sub 1-1",       32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 4'b0000});
        vecs.push_back('{"mul 1.5*2",     32'h3FC00000, 32'h40000000, 2'b11, 32'h40400000, 4'b0000});
        vecs.push_back('{"mul ovf",       32'h7F000000, 32'h40000000, 2'b11, 32'h7F800000, 4'b0010});
        vecs.push_back('{"div 1/3",       32'h3F800000, 32'h40400000, 2'b10,
                         DIV_ON ? 32'h3EAAAAAA : QNAN, DIV_ON ? 4'b0000 : 4'b1000});
        vecs.push_back('{"div 1/0",       32'h3F800000, 32'h00000000, 2'b10,
                         DIV_ON ? 32'h7F800000 : QNAN, DIV_ON ? 4'b0100 : 4'b1000});
        vecs.push_back('{"div 0/0",       32'h00000000, 32'h00000000, 2'b10, QNAN, 4'b1000});
        vecs.push_back('{"div 6/3",       32'h40C00000, 32'h40400000, 2'b10,
                         DIV_ON ? 32'h40000000 : QNAN, DIV_ON ? 4'b0000 : 4'b1000});
        vecs.push_back('{"add nan",       32'h7F800001, 32'h3F800000, 2'b00, QNAN, 4'b1000});
        vecs.push_back('{"sub inf-inf",   32'h7F800000, 32'h7F800000, 2'b01, QNAN, 4'b1000});
        vecs.push_back('{"add inf+-inf",  32'h7F800000, 32'hFF800000, 2'b00, QNAN, 4'b1000});
        vecs.push_back('{"add -inf+1",    32'hFF800000, 32'h3F800000, 2'b00, 32'hFF800000, 4'b0000});
        vecs.push_back('{"mul 0*inf",     32'h00000000, 32'h7F800000, 2'b11, QNAN, 4'b1000});
        vecs.push_back('{"mul inf*-2",    32'h7F800000, 32'hC0000000, 2'b11, 32'hFF800000, 4'b0000});
        vecs.push_back('{"mul unf",       32'h00800000, 32'h00800000, 2'b11, 32'h00000000, 4'b0001});
        vecs.push_back('{"mul -2*3",      32'hC0000000, 32'h40400000, 2'b11, 32'hC0C00000, 4'b0000});
        vecs.push_back('{"add denorm",    32'h00000001, 32'h3F800000, 2'b00, 32'h3F800000, 4'b0000});
        vecs.push_back('{"add ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F800000, 4'b0010});
        vecs.push_back('{"sub 1-2^-24",   32'h3F800000, 32'h33800000, 2'b01, 32'h3F7FFFFF, 4'b0000});
        vecs.push_back('{"add -2+2",      32'hC0000000, 32'h40000000, 2'b00, 32'h00000000, 4'b0000});
        vecs.push_back('{"add -0+-0",     32'h80000000, 32'h80000000, 2'b00, 32'h80000000, 4'b0000});
        vecs.push_back('{"add 2^23+1",    32'h4B000000, 32'h3F800000, 2'b00, 32'h4B000001, 4'b0000});
        vecs.push_back('{"add far",       32'h5F000000, 32'h3F800000, 2'b00, 32'h5F000000, 4'b0000});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset result",    result,             32'd0);
        checkOutput("reset flags",     {28'b0, flags},     32'd0);

        foreach (vecs[i]) runVector(vecs[i]);

        // Backpressure: result must hold while the consumer stalls, and new input is refused.
        out_ready = 1'b0;
        applyStimulus(32'h3FC00000, 32'h40100000, 2'b00, lat, ir1);
        checkOutput("bp latency", lat, 3);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = 32'h40000000; b = 32'h40000000; opcode = 2'b11;
            @(negedge clk);
            checkOutput("bp out_valid held", {31'b0, out_valid}, 32'd1);
            checkOutput("bp result held",    result,             32'h40700000);
            checkOutput("bp in_ready low",   {31'b0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp release in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("bp release out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("bp no stray accept", {31'b0, in_ready}, 32'd1);
        checkOutput("bp result kept",     result,            32'h40700000);

        // Reset in the middle of a division aborts it and clears the outputs.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; opcode = 2'b10; in_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-div rst in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("mid-div rst out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid-div rst result",    result,             32'd0);
        checkOutput("mid-div rst flags",     {28'b0, flags},     32'd0);
        rst = 1'b0;
        runVector(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/fpu_seq.md
# fpu_seq

Parametrised, handshaked floating-point arithmetic unit and the successor to the single-cycle IEEE 754 single-precision ALU. It accepts one operand pair at a time and computes add, sub, mul or div. Add, sub and mul complete at a fixed latency; div uses an iterative restoring divider. Results are returned with full special-value handling and status flags through a valid/ready output port, so the block can sit behind an issue stage and stall cleanly.

## Interface
- EXP_W, default 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, default 23, stored fraction width; the hidden bit is implicit.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand pair and opcode present.
- in_ready  out  1  block can accept; high only in IDLE.
- a, b  in  1+EXP_W+MAN_W  operands, packed sign|exponent|fraction.
- opcode  in  2  00 add, 01 sub (a-b), 10 div (a/b), 11 mul.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  1+EXP_W+MAN_W  packed result.
- flags  out  4  {invalid, div_by_zero, overflow, underflow}.

## Operation
- FSM states: IDLE, EXEC, NORM, DONE.
- IDLE → EXEC on in_valid&&in_ready. a, b and opcode are registered on acceptance; later input changes are ignored.
- Unpack in EXEC:
  - Exponent 0 means zero; denormals are flushed to zero (sign kept).
  - Exponent all-ones with fraction 0 means ±inf; with fraction ≠0 it means NaN.
- Add/sub:
  - Sub flips b's sign, then shares the add path.
  - Align the smaller-exponent significand right by the exponent difference. A difference > MAN_W+3 reduces it to 0.
  - Keep 3 extra low bits (guard, round, sticky) during alignment.
  - Magnitude subtract always takes larger minus smaller; the result sign is the larger operand's sign.
  - Exact zero from cancellation is +0.
- Mul: the (MAN_W+1)×(MAN_W+1) product is formed in EXEC. Exponent = ea+eb-bias, computed in EXP_W+2 signed bits.
- Div: restoring division, one quotient bit per cycle for MAN_W+2 cycles in EXEC. Exponent = ea-eb+bias. The iteration counter clears on entry.
- NORM (one cycle):
  - Leading-one normalise: right shift ≤1, left shift ≤MAN_W+2, with the exponent adjusted to match.
  - Truncate (round toward zero).
  - Apply range checks:
    - Exponent ≥ 2^EXP_W-1 → ±inf, overflow=1.
    - Exponent ≤ 0 → ±0, underflow=1.
- Special cases override the datapath result:
  - Any NaN operand → canonical qNaN (sign 0, exponent all-ones, fraction MSB only), invalid=1.
  - inf-inf (effective), 0×inf, 0/0, inf/inf → qNaN, invalid=1.
  - x/0 with x finite and nonzero → ±inf, div_by_zero=1.
  - inf ± finite → that inf.
  - Mul/div signs are sa^sb.
- DONE: out_valid=1; result and flags are held stable until out_ready. On out_valid&&out_ready → IDLE.
- rst in any state → IDLE, aborting any operation in flight. Reset values: in_ready=1, out_valid=0, result=0, flags=0.

## Timing
- The acceptance edge is cycle 0.
- Add/sub/mul: out_valid rises at cycle 3 (EXEC 1 cycle, NORM 1 cycle).
- Div: out_valid rises at cycle MAN_W+4 (27 with defaults).
- Special-case operands take the same latency as their opcode.
- in_ready=0 from cycle 1 until the cycle after the out_valid&&out_ready handshake; there is no same-cycle re-accept.
- If out_ready=1 when out_valid rises, out_valid is high for one cycle only.
- result and flags change only on entry to DONE or on rst.

## Configuration
- FPU_DIV_EN defined: the divider datapath and its iteration counter are built, and div behaves as above.
- FPU_DIV_EN undefined: no divider logic is built. Opcode 10 returns canonical qNaN with invalid=1 at the 3-cycle latency.

## Test plan
- add 0x3FC00000 + 0x40100000 (1.5+2.25) → result 0x40700000, flags 0, out_valid at cycle 3.
- sub 0x40400000 - 0x40A00000 (3-5) → 0xC0000000. Then sub 0x3F800000 - 0x3F800000 → 0x00000000 (+0).
- mul 0x3FC00000 × 0x40000000 → 0x40400000. Then mul 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1.
- div 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA at cycle 27. Then div 0x3F800000 / 0x00000000 → 0x7F800000, div_by_zero=1. Then div 0 / 0 → 0x7FC00000, invalid=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result stable, in_ready=0, a second in_valid is not accepted. Then assert out_ready → IDLE and in_ready=1 the next cycle.
- Assert rst at cycle 10 of a division → the next cycle has in_ready=1, out_valid=0, result=0, flags=0. A fresh add then completes correctly.
